// File: rtl/ct_spsram_128x16_arb.sv
`default_nettype none
// =============================================================================
// Module   : ct_spsram_128x16_arb
// Desc     : Two-requester round-robin arbiter in front of one single-port SRAM.
//            Optional power-up clear sweep enabled by CT_SPSRAM_ARB_INIT_EN.
// Revision : 1.0 - initial release
// =============================================================================
module ct_spsram_128x16_arb #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req0_vld,
    input  logic                  req0_wr,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic [DATA_WIDTH-1:0] req0_wmask,
    output logic                  req0_rdy,
    input  logic                  req1_vld,
    input  logic                  req1_wr,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic [DATA_WIDTH-1:0] req1_wmask,
    output logic                  req1_rdy,
    output logic                  rsp_vld,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

`ifdef CT_SPSRAM_ARB_INIT_EN
    localparam state_t C_RST_STATE = ST_INIT;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
`else
    localparam state_t C_RST_STATE = ST_RUN;
`endif

    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   rsp_pend_q, rsp_pend_d;
    logic   rsp_id_q, rsp_id_d;

    logic                  w_run;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_gnt;
    logic                  w_sel;
    logic                  w_wr;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_wmask;

    // last_q names the previous winner; on contention the other side wins.
    assign w_run   = (state_q == ST_RUN) && !RST;
    assign w_gnt0  = w_run && req0_vld && (!req1_vld || last_q);
    assign w_gnt1  = w_run && req1_vld && (!req0_vld || !last_q);
    assign w_gnt   = w_gnt0 || w_gnt1;
    assign w_sel   = w_gnt1;
    assign w_wr    = w_sel ? req1_wr    : req0_wr;
    assign w_addr  = w_sel ? req1_addr  : req0_addr;
    assign w_wdata = w_sel ? req1_wdata : req0_wdata;
    assign w_wmask = w_sel ? req1_wmask : req0_wmask;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        rsp_pend_d = w_gnt && !w_wr;
        rsp_id_d   = w_sel;
        sram_cen   = 1'b1;
        sram_gwen  = 1'b1;
        sram_wen   = '1;
        sram_a     = '0;
        sram_d     = '0;
`ifdef CT_SPSRAM_ARB_INIT_EN
        cnt_d      = cnt_q;
`endif
        if (w_gnt) begin
            last_d   = w_sel;
            sram_cen = 1'b0;
            sram_a   = w_addr;
            if (w_wr) begin
                sram_gwen = 1'b0;
                sram_wen  = ~w_wmask;
                sram_d    = w_wdata;
            end
        end
`ifdef CT_SPSRAM_ARB_INIT_EN
        else if ((state_q == ST_INIT) && !RST) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = cnt_q;
            cnt_d     = cnt_q + ADDR_WIDTH'(1);
            // Counter wraps to zero here; the sweep only restarts via reset.
            if (cnt_q == '1) begin
                state_d = ST_RUN;
            end
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= C_RST_STATE;
            last_q     <= 1'b1;
            rsp_pend_q <= 1'b0;
            rsp_id_q   <= 1'b0;
`ifdef CT_SPSRAM_ARB_INIT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            rsp_pend_q <= rsp_pend_d;
            rsp_id_q   <= rsp_id_d;
`ifdef CT_SPSRAM_ARB_INIT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // SRAM read data lands one cycle after the grant and is passed straight out.
    assign rsp_vld   = rsp_pend_q && !RST;
    assign rsp_id    = rsp_vld && rsp_id_q;
    assign rsp_data  = rsp_vld ? sram_q : '0;
    assign req0_rdy  = w_gnt0;
    assign req1_rdy  = w_gnt1;
    assign init_done = (state_q == ST_RUN) && !RST;

endmodule
`default_nettype wire

// File: tb/tb_ct_spsram_128x16_arb.sv
`default_nettype none
// =============================================================================
// Module   : tb_ct_spsram_128x16_arb
// Desc     : Self-checking bench for ct_spsram_128x16_arb (directed table,
//            reset corner sequences, randomized traffic vs reference model).
// Revision : 1.0 - initial release
// =============================================================================
module tb_ct_spsram_128x16_arb;

    localparam int AW = 7;
    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          req0_vld, req0_wr, req1_vld, req1_wr;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_wdata, req0_wmask, req1_wdata, req1_wmask;
    logic          req0_rdy, req1_rdy, rsp_vld, rsp_id, init_done;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] sram_a;
    logic          sram_cen, sram_gwen;
    logic [DW-1:0] sram_wen, sram_d;
    logic [DW-1:0] sram_q = '0;
    logic [DW-1:0] mem [0:127] = '{default: '0};

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    ct_spsram_128x16_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST),
        .req0_vld(req0_vld), .req0_wr(req0_wr), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_wmask(req0_wmask), .req0_rdy(req0_rdy),
        .req1_vld(req1_vld), .req1_wr(req1_wr), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_wmask(req1_wmask), .req1_rdy(req1_rdy),
        .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .init_done(init_done),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
        .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
    );

    // Single-port SRAM: per-bit active-low write enable, registered read.
    always @(posedge CLK) begin
        if (!sram_cen) begin
            if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q      <= mem[sram_a];
        end
    end

    typedef struct packed {
        logic v0; logic w0; logic [AW-1:0] a0; logic [DW-1:0] d0; logic [DW-1:0] m0;
        logic v1; logic w1; logic [AW-1:0] a1; logic [DW-1:0] d1; logic [DW-1:0] m1;
        logic [1:0] rdy; logic rv; logic rid; logic [DW-1:0] rd;
        logic cen; logic gwen; logic [DW-1:0] wen; logic [AW-1:0] a;
    } vec_t;

    vec_t tbl [0:12];

    function automatic vec_t mk(
        input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0, input logic [DW-1:0] m0,
        input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1, input logic [DW-1:0] m1,
        input logic [1:0] rdy, input logic rv, input logic rid, input logic [DW-1:0] rd,
        input logic cen, input logic gwen, input logic [DW-1:0] wen, input logic [AW-1:0] a);
        return '{v0, w0, a0, d0, m0, v1, w1, a1, d1, m1, rdy, rv, rid, rd, cen, gwen, wen, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_in();
        req0_vld = 0; req0_wr = 0; req0_addr = '0; req0_wdata = '0; req0_wmask = '0;
        req1_vld = 0; req1_wr = 0; req1_addr = '0; req1_wdata = '0; req1_wmask = '0;
    endtask

    // Entered at posedge+1 of the first cycle with RST low; leaves in RUN.
    task automatic wait_init();
`ifdef CT_SPSRAM_ARB_INIT_EN
        req0_vld = 1; req1_vld = 1;
        for (int i = 0; i < 128; i++) begin
            @(negedge CLK);
            check("init_sweep",
                  {sram_cen, sram_gwen, sram_wen, sram_a, sram_d, req0_rdy, req1_rdy, init_done, rsp_vld},
                  {1'b0, 1'b0, 16'h0000, 7'(i), 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});
            next_cyc();
        end
        idle_in();
`endif
        @(negedge CLK);
        check("init_done", {init_done, rsp_vld, sram_cen}, {1'b1, 1'b0, 1'b1});
        next_cyc();
    endtask

    // Reference model state for randomized traffic.
    logic [DW-1:0] ref_mem [0:127];
    int            ref_last;
    logic          pend_v, pend_id;
    logic [DW-1:0] pend_d;
    logic          p0, p1;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //                v0 w0 a0 d0       m0        v1 w1 a1 d1       m1        rdy    rv rid rd        cen gwen wen       a
        tbl[0]  = mk(1, 1, 5, 16'hA5A5, 16'hFFFF, 0, 0, 0, 16'h0000, 16'h0000, 2'b10, 0, 0, 16'h0000, 0, 0, 16'h0000, 5);
        tbl[1]  = mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 5, 16'h0000, 16'h0000, 2'b01, 0, 0, 16'h0000, 0, 1, 16'hFFFF, 5);
        tbl[2]  = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 1, 1, 16'hA5A5, 1, 1, 16'hFFFF, 0);
        tbl[3]  = mk(1, 0, 5, 16'h0000, 16'h0000, 1, 0, 9, 16'h0000, 16'h0000, 2'b10, 0, 0, 16'h0000, 0, 1, 16'hFFFF, 5);
        tbl[4]  = mk(1, 0, 5, 16'h0000, 16'h0000, 1, 0, 9, 16'h0000, 16'h0000, 2'b01, 1, 0, 16'hA5A5, 0, 1, 16'hFFFF, 9);
        tbl[5]  = mk(1, 0, 5, 16'h0000, 16'h0000, 1, 0, 9, 16'h0000, 16'h0000, 2'b10, 1, 1, 16'h0000, 0, 1, 16'hFFFF, 5);
        tbl[6]  = mk(1, 0, 5, 16'h0000, 16'h0000, 1, 0, 9, 16'h0000, 16'h0000, 2'b01, 1, 0, 16'hA5A5, 0, 1, 16'hFFFF, 9);
        tbl[7]  = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 1, 1, 16'h0000, 1, 1, 16'hFFFF, 0);
        tbl[8]  = mk(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 9, 16'hFFFF, 16'h00F0, 2'b01, 0, 0, 16'h0000, 0, 0, 16'hFF0F, 9);
        tbl[9]  = mk(1, 0, 9, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 2'b10, 0, 0, 16'h0000, 0, 1, 16'hFFFF, 9);
        tbl[10] = mk(1, 1, 9, 16'h1234, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 2'b10, 1, 0, 16'h00F0, 0, 0, 16'hFFFF, 9);
        tbl[11] = mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 9, 16'h0000, 16'h0000, 2'b01, 0, 0, 16'h0000, 0, 1, 16'hFFFF, 9);
        tbl[12] = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 1, 1, 16'h00F0, 1, 1, 16'hFFFF, 0);

        // Reset state, with requests present to show they are not accepted.
        RST = 1;
        idle_in();
        repeat (3) @(posedge CLK);
        #1;
        req0_vld = 1; req1_vld = 1;
        @(negedge CLK);
        check("reset_out",
              {rsp_vld, rsp_id, rsp_data, req0_rdy, req1_rdy, init_done, sram_cen, sram_gwen, sram_wen},
              {1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF});
        next_cyc();
        RST = 0;
        idle_in();
        wait_init();

        for (int i = 0; i < 13; i++) begin
            req0_vld = tbl[i].v0; req0_wr = tbl[i].w0; req0_addr = tbl[i].a0;
            req0_wdata = tbl[i].d0; req0_wmask = tbl[i].m0;
            req1_vld = tbl[i].v1; req1_wr = tbl[i].w1; req1_addr = tbl[i].a1;
            req1_wdata = tbl[i].d1; req1_wmask = tbl[i].m1;
            @(negedge CLK);
            check($sformatf("tbl_row%0d", i),
                  {req0_rdy, req1_rdy, rsp_vld, rsp_id, rsp_data, sram_cen, sram_gwen, sram_wen, sram_a},
                  {tbl[i].rdy, tbl[i].rv, tbl[i].rid, tbl[i].rd, tbl[i].cen, tbl[i].gwen, tbl[i].wen, tbl[i].a});
            next_cyc();
        end
        idle_in();

        // Reset coinciding with a would-be read grant.
        req0_vld = 1; req0_addr = 5; RST = 1;
        @(negedge CLK);
        check("rst_on_grant", {req0_rdy, sram_cen, rsp_vld}, {1'b0, 1'b1, 1'b0});
        next_cyc();
        RST = 0;
        idle_in();
        wait_init();

        // Reset while a granted read is waiting for its response.
        req1_vld = 1; req1_addr = 5;
        @(negedge CLK);
        check("inflight_gnt", {req1_rdy, sram_cen, sram_gwen}, {1'b1, 1'b0, 1'b1});
        next_cyc();
        idle_in();
        RST = 1;
        @(negedge CLK);
        check("inflight_drop", {rsp_vld, rsp_id, rsp_data}, {1'b0, 1'b0, 16'h0000});
        next_cyc();
        RST = 0;
        @(negedge CLK);
        check("inflight_after", rsp_vld, 1'b0);
        next_cyc();
        RST = 1;
        next_cyc();
        RST = 0;
        wait_init();

`ifdef CT_SPSRAM_ARB_INIT_EN
        // Reset pulse in the middle of the clear sweep.
        RST = 1;
        next_cyc();
        RST = 0;
        for (int i = 0; i < 60; i++) next_cyc();
        @(negedge CLK);
        check("midinit_addr", {sram_a, sram_cen}, {7'd60, 1'b0});
        next_cyc();
        RST = 1;
        @(negedge CLK);
        check("midinit_rst", {sram_cen, init_done}, {1'b1, 1'b0});
        next_cyc();
        RST = 0;
        wait_init();
`endif

        // Randomized traffic; addresses 16..31 are untouched by earlier phases.
        RST = 1;
        next_cyc();
        RST = 0;
        wait_init();
        for (int k = 0; k < 128; k++) ref_mem[k] = '0;
        ref_last = 1;
        pend_v = 0; pend_id = 0; pend_d = '0;
        p0 = 0; p1 = 0;
        for (int c = 0; c < 400; c++) begin
            int            g;
            logic          gw;
            logic [AW-1:0] ga;
            logic [DW-1:0] gd, gm;
            logic [40:0]   exp_pins, act_pins;
            if (!p0 && ($urandom_range(2, 0) != 0)) begin
                p0 = 1; req0_wr = $urandom_range(1, 0) == 1; req0_addr = 7'($urandom_range(31, 16));
                req0_wdata = 16'($urandom);
                req0_wmask = ($urandom_range(3, 0) == 0) ? 16'h0000 : 16'($urandom);
            end
            if (!p1 && ($urandom_range(2, 0) != 0)) begin
                p1 = 1; req1_wr = $urandom_range(1, 0) == 1; req1_addr = 7'($urandom_range(31, 16));
                req1_wdata = 16'($urandom);
                req1_wmask = ($urandom_range(3, 0) == 0) ? 16'hFFFF : 16'($urandom);
            end
            req0_vld = p0;
            req1_vld = p1;

            if (p0 && p1) g = (ref_last == 1) ? 0 : 1;
            else if (p0)  g = 0;
            else if (p1)  g = 1;
            else          g = -1;
            gw = (g == 1) ? req1_wr    : req0_wr;
            ga = (g == 1) ? req1_addr  : req0_addr;
            gd = (g == 1) ? req1_wdata : req0_wdata;
            gm = (g == 1) ? req1_wmask : req0_wmask;

            if (g < 0)   exp_pins = {1'b1, 1'b1, 16'hFFFF, 7'd0, 16'h0000};
            else if (gw) exp_pins = {1'b0, 1'b0, ~gm, ga, gd};
            else         exp_pins = {1'b0, 1'b1, 16'hFFFF, ga, 16'h0000};

            @(negedge CLK);
            act_pins = {sram_cen, sram_gwen, sram_wen, sram_a, ((g >= 0 && !gw) ? 16'h0000 : sram_d)};
            check("rand_rdy", {req0_rdy, req1_rdy}, {g == 0, g == 1});
            check("rand_sram", act_pins, exp_pins);
            check("rand_rsp", {rsp_vld, rsp_id, rsp_data},
                  {pend_v, pend_v && pend_id, (pend_v ? pend_d : 16'h0000)});

            pend_v = 0;
            if (g >= 0) begin
                ref_last = g;
                if (gw) ref_mem[ga] = (ref_mem[ga] & ~gm) | (gd & gm);
                else begin
                    pend_v  = 1;
                    pend_id = (g == 1);
                    pend_d  = ref_mem[ga];
                end
                if (g == 0) p0 = 0;
                else        p1 = 0;
            end
            next_cyc();
        end
        idle_in();
        @(negedge CLK);
        check("rand_tail_rsp", {rsp_vld, rsp_id, rsp_data},
              {pend_v, pend_v && pend_id, (pend_v ? pend_d : 16'h0000)});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ct_spsram_128x16_arb.md
CT_SPSRAM_128X16_ARB -- requirements
Module: ct_spsram_128x16_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 7, SRAM word address width (128 entries).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, SRAM data and bit-mask width.
REQ-003 SHALL have ports: CLK  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have ports: RST  in  1  reset, synchronous and active-high.
REQ-005 SHALL have ports: reqN_vld  in  1  requester N access valid (N = 0, 1).
REQ-006 SHALL have ports: reqN_wr  in  1  1 = write, 0 = read.
REQ-007 SHALL have ports: reqN_addr  in  ADDR_WIDTH  word address.
REQ-008 SHALL have ports: reqN_wdata  in  DATA_WIDTH  write data.
REQ-009 SHALL have ports: reqN_wmask  in  DATA_WIDTH  active-high bit write mask.
REQ-010 SHALL have ports: reqN_rdy  out  1  request accepted this cycle.
REQ-011 SHALL have ports: rsp_vld  out  1, rsp_id  out  1, rsp_data  out  DATA_WIDTH  read return.
REQ-012 SHALL have ports: init_done  out  1  controller ready for requests.
REQ-013 SHALL have ports: sram_a  out  ADDR_WIDTH, sram_cen  out  1 (active-low), sram_gwen  out  1 (active-low), sram_wen  out  DATA_WIDTH (active-low per bit), sram_d  out  DATA_WIDTH, sram_q  in  DATA_WIDTH  to the single-port SRAM.

Function
REQ-014 SHALL use FSM states INIT (clear sweep) and RUN; at most one SRAM access per cycle.
REQ-015 SHALL in RUN grant combinationally: only one vld -> that requester; both vld -> the requester not granted last (round-robin).
REQ-016 SHALL hold a last-grant register, reset to 1 (requester 0 wins the first contention), updated on every grant.
REQ-017 SHALL assert reqN_rdy only for the granted requester in the grant cycle; vld without rdy is held by the requester, with fields stable.
REQ-018 SHALL on grant drive sram_cen=0, sram_a=addr; write: sram_gwen=0, sram_wen=~wmask, sram_d=wdata; read: sram_gwen=1, sram_wen=all 1.
REQ-019 SHALL on no access drive sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0.
REQ-020 SHALL for a granted read in cycle T assert rsp_vld in T+1 with rsp_data=sram_q and rsp_id=granted index; writes produce no response.
REQ-021 SHALL sustain back-to-back reads (one response per cycle, in grant order).
REQ-022 SHALL treat a write with wmask=0 as a normal one-cycle write slot that leaves memory unchanged.
REQ-023 SHALL in INIT write 0 to addresses 0..127 in ascending order (sram_wen=all 0), one per cycle, with reqN_rdy=0; after address 127, go to RUN and set init_done=1 the next cycle.
REQ-024 SHALL keep the INIT address counter at ADDR_WIDTH bits; wrap from 127 ends the sweep and never restarts it outside reset.

Reset
REQ-025 SHALL while RST=1 drive rsp_vld=0, rsp_id=0, rsp_data=0, reqN_rdy=0, init_done=0, sram_cen=1, sram_gwen=1, sram_wen=all 1.
REQ-026 SHALL on RST during any state, including mid-INIT or with a read in flight, drop the pending response and restart from the post-reset state (INIT or RUN per REQ-027).

Configuration
REQ-027 SHALL gate the clear sweep with CT_SPSRAM_ARB_INIT_EN: defined -> enter INIT after reset (init_done after 128 sweep cycles + 1); undefined -> enter RUN directly, init_done=1 the first cycle after RST deasserts, and omit the INIT counter.

Verification
REQ-028 SHALL cover INIT_EN defined, reset released -> 128 writes of 0 to 0..127, rdy=0 throughout, init_done=1 on cycle 129.
REQ-029 SHALL cover req0 write addr 5 data 0xA5A5 mask 0xFFFF, then req1 read addr 5 -> rsp_vld next cycle, rsp_id=1, rsp_data=0xA5A5.
REQ-030 SHALL cover both vld held 4 cycles (reads) -> grants 0,1,0,1; responses ids 0,1,0,1 one cycle later each.
REQ-031 SHALL cover write addr 9 data 0xFFFF mask 0x00F0 over 0x0000 -> read returns 0x00F0; mask 0 write -> data unchanged.
REQ-032 SHALL cover RST pulsed one cycle during INIT at address 60 and on a read grant cycle -> no rsp_vld, sweep restarts at address 0.
